// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key expansion: emits round keys 0..10, one strobe every
// other cycle, using a registered SubWord stage on RotWord(w3).

module aes128_subword (
    input  logic        clk,
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // Forward S-box, row 0 in the most significant bits; entry x sits at index ~x.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[~x];
    endfunction

    always_ff @(posedge clk) begin
        word_out <= {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};
    end

endmodule

module aes128_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] round_key,
    output logic         done
);

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam logic [3:0]  LAST_ROUND = 4'd10;

    typedef enum logic [1:0] {IDLE, SUB, MIX} state_t;

    state_t              state;
    logic [KEY_W-1:0]    key_q;
    logic [3:0]          cnt_q;
    logic [7:0]          rcon_q;
    logic [WORD_W-1:0]   rot_word_c;
    logic [WORD_W-1:0]   sub_word;
    logic [WORD_W-1:0]   t_c;
    logic [WORD_W-1:0]   n0_c, n1_c, n2_c, n3_c;
    logic [7:0]          rcon_next_c;

    assign rot_word_c = {key_q[23:0], key_q[31:24]};

    aes128_subword u_subword (
        .clk      (clk),
        .word_in  (rot_word_c),
        .word_out (sub_word)
    );

    // Next round key from the current key words and the substituted word.
    always_comb begin
        t_c         = sub_word ^ {rcon_q, 24'h0};
        n0_c        = key_q[127:96] ^ t_c;
        n1_c        = key_q[95:64]  ^ n0_c;
        n2_c        = key_q[63:32]  ^ n1_c;
        n3_c        = key_q[31:0]   ^ n2_c;
        rcon_next_c = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_q     <= '0;
            cnt_q     <= '0;
            rcon_q    <= 8'h01;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            rk_round  <= '0;
            round_key <= '0;
            done      <= 1'b0;
        end else begin
            rk_valid <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        key_q     <= key_in;
                        round_key <= key_in;
                        rk_round  <= 4'd0;
                        rk_valid  <= 1'b1;
                        busy      <= 1'b1;
                        cnt_q     <= 4'd1;
                        rcon_q    <= 8'h01;
                        state     <= SUB;
                    end
                end
                SUB: state <= MIX;
                MIX: begin
                    key_q     <= {n0_c, n1_c, n2_c, n3_c};
                    round_key <= {n0_c, n1_c, n2_c, n3_c};
                    rk_round  <= cnt_q;
                    rk_valid  <= 1'b1;
                    rcon_q    <= rcon_next_c;
                    cnt_q     <= cnt_q + 4'd1;
                    if (cnt_q == LAST_ROUND) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= SUB;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_key_expand.sv
// Bench for aes128_key_expand: cycle-exact checks against a FIPS-197 style
// key-schedule model whose S-box is derived from GF(2^8) inversion.

module tb_aes128_key_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] round_key;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] rk_model [11];
    logic [127:0] cap [11];
    logic [7:0]   rcon_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes128_key_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_round  (rk_round),
        .round_key (round_key),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    // S-box = affine(multiplicative inverse), built from first principles.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] av = 8'(a);
            for (int b = 1; b < 256; b++)
                if (gmul(av, 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic logic [31:0] rotw(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = subw(rotw(temp)) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++)
            rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Runs one expansion from the current cycle; returns after edge T+20 + 1.
    task automatic do_expand(input logic [127:0] key, input bit interfere);
        int nvalid = 0;
        int r;
        logic [127:0] prev;
        logic [31:0]  t;
        model_expand(key);
        start  = 1'b1;
        key_in = key;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) start = 1'b0;
            if (interfere && k == 4) start = 1'b1;
            if (interfere && k == 5) begin
                start  = 1'b0;
                key_in = ~key;
            end
            if (rk_valid) nvalid++;
            if (k % 2 == 0) begin
                r = k / 2;
                chk($sformatf("valid_r%0d", r), 128'(rk_valid), 128'(1));
                chk($sformatf("round_r%0d", r), 128'(rk_round), 128'(r));
                chk($sformatf("key_r%0d", r), round_key, rk_model[r]);
                chk($sformatf("done_r%0d", r), 128'(done), 128'(k == 20));
                chk($sformatf("busy_r%0d", r), 128'(busy), 128'(k != 20));
                cap[r] = round_key;
            end else begin
                chk($sformatf("gap_valid_c%0d", k), 128'(rk_valid), 128'(0));
                chk($sformatf("gap_busy_c%0d", k), 128'(busy), 128'(1));
            end
        end
        chk("strobe_count", 128'(nvalid), 128'(11));
        for (int i = 1; i <= 10; i++) begin
            prev = cap[i-1];
            t    = cap[i][127:96] ^ prev[127:96];
            chk($sformatf("rcon_r%0d", i), 128'(t ^ subw(rotw(prev[31:0]))),
                128'({rcon_exp[i-1], 24'h0}));
        end
    endtask

    task automatic idle_hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("hold_key", round_key, cap[10]);
            chk("hold_round", 128'(rk_round), 128'(10));
            chk("hold_valid", 128'(rk_valid), 128'(0));
            chk("hold_busy", 128'(busy), 128'(0));
        end
    endtask

    initial begin
        int nstrobe;
        logic [127:0] rkey;
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        build_sbox();
        #12;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(rk_valid), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_round", 128'(rk_round), 128'(0));
        chk("rst_key", round_key, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_expand(KEY_A1, 1'b0);
        chk("a1_r0", cap[0], KEY_A1);
        chk("a1_r1", cap[1], A1_R1);
        chk("a1_r10", cap[10], A1_R10);
        idle_hold(3);

        do_expand(128'h0, 1'b0);
        chk("zero_r1", cap[1], ZERO_R1);
        chk("zero_r10", cap[10], ZERO_R10);
        idle_hold(2);

        rkey = {$urandom, $urandom, $urandom, $urandom};
        do_expand(rkey, 1'b1);
        do_expand(KEY_A1, 1'b0);
        chk("b2b_r1", cap[1], A1_R1);
        chk("b2b_r10", cap[10], A1_R10);
        idle_hold(2);

        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_valid", 128'(rk_valid), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_round", 128'(rk_round), 128'(0));
        chk("abort_key", round_key, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nstrobe = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (rk_valid) nstrobe++;
        end
        chk("abort_no_strobes", 128'(nstrobe), 128'(0));
        chk("abort_idle_busy", 128'(busy), 128'(0));
        do_expand({$urandom, $urandom, $urandom, $urandom}, 1'b0);

        for (int n = 0; n < 3; n++) begin
            int gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
            do_expand({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
